// File: rtl/hex_rate_counter_pkg.sv
// Shared definitions for the hex rate counter: speed codes and divider reload values.
`timescale 1ns/1ps
package hex_counter_defs;

  localparam logic [1:0] SPD_FAST = 2'b00;
  localparam logic [1:0] SPD_1S   = 2'b01;
  localparam logic [1:0] SPD_2S   = 2'b10;
  localparam logic [1:0] SPD_4S   = 2'b11;

  // Reload value R(speed); a period lasts R+1 enabled cycles.
  function automatic logic [33:0] reload_value(input logic [1:0] spd, input int unsigned clk_hz);
    logic [33:0] hz;
    hz = 34'(clk_hz);
    case (spd)
      SPD_FAST: reload_value = 34'd0;
      SPD_1S:   reload_value = hz - 34'd1;
      SPD_2S:   reload_value = (hz << 1) - 34'd1;
      default:  reload_value = (hz << 2) - 34'd1;
    endcase
  endfunction

endpackage

// File: rtl/hex_rate_counter_rate_divider.sv
// Programmable rate divider: emits a one-cycle advance pulse every R(speed)+1 enabled cycles.
`timescale 1ns/1ps
module rate_divider
  import hex_counter_defs::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       restart,
  output logic       pulse
);

  localparam int DIV_W = $clog2(4 * CLK_HZ);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [DIV_W-1:0] reload;
  logic [1:0]       speed_q;
  logic [1:0]       speed_next;
  logic             speed_change;

  assign reload       = DIV_W'(reload_value(speed, CLK_HZ));
  assign speed_change = (speed != speed_q);

  // A restart or a new speed code begins a full-length period and never advances.
  always_comb begin
    div_next   = div;
    speed_next = speed_q;
    pulse      = 1'b0;
    if (restart || speed_change) begin
      div_next   = reload;
      speed_next = speed;
    end else if (enable) begin
      if (div == '0) begin
        div_next = reload;
        pulse    = 1'b1;
      end else begin
        div_next = div - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div     <= '0;
      speed_q <= SPD_FAST;
    end else begin
      div     <= div_next;
      speed_q <= speed_next;
    end
  end

endmodule

// File: rtl/hex_rate_counter.sv
// Rate-divided loadable up/down hex counter feeding the seven-segment decoder.
`timescale 1ns/1ps
module hex_rate_counter
  import hex_counter_defs::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] count,
  output logic       tick,
  output logic       wrap
);

  logic       pulse;
  logic [3:0] count_reg;
  logic [3:0] count_next;
  logic       tick_reg;
  logic       tick_next;
  logic       wrap_reg;
  logic       wrap_next;

  rate_divider #(
    .CLK_HZ (CLK_HZ)
  ) u_rate_divider (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (enable),
    .speed   (speed),
    .restart (load),
    .pulse   (pulse)
  );

  // Load outranks an advance; the divider already suppresses pulse on load.
  always_comb begin
    count_next = count_reg;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_value;
    end else if (pulse) begin
      tick_next = 1'b1;
      if (up) begin
        count_next = count_reg + 4'd1;
        wrap_next  = (count_reg == 4'hF);
      end else begin
        count_next = count_reg - 4'd1;
        wrap_next  = (count_reg == 4'h0);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_reg <= 4'h0;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tick_reg  <= tick_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed self-checking bench for hex_rate_counter with CLK_HZ=4.
`timescale 1ns/1ps
module tb_hex_rate_counter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       enable;
  logic [1:0] speed;
  logic       up;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic       tick;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  hex_rate_counter #(
    .CLK_HZ (4)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .speed      (speed),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tick       (tick),
    .wrap       (wrap)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks count/tick/wrap together and prints one line per transaction.
  task automatic expect_out(input string tag, input logic [3:0] c, input logic t, input logic w);
    $display("%0t %s count=%0h tick=%0b wrap=%0b", $time, tag, count, tick, wrap);
    check({tag, ".count"}, count, c);
    check({tag, ".tick"}, {3'b0, tick}, {3'b0, t});
    check({tag, ".wrap"}, {3'b0, wrap}, {3'b0, w});
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; speed = 2'b00; up = 1'b1;
    load = 1'b0; load_value = 4'h0;
    step(); step();
    expect_out("reset", 4'h0, 1'b0, 1'b0);
    resetn = 1'b1;
    enable = 1'b1;

    // Fast count up through a wrap.
    for (int i = 1; i <= 18; i++) begin
      step();
      expect_out("fast_up", 4'(i % 16), 1'b1, (i % 16) == 0);
    end

    // Speed 01: switch edge reloads, then one advance per 4 cycles.
    speed = 2'b01;
    step();
    expect_out("spd1_switch", 4'h2, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        step();
        expect_out("spd1_wait", 4'(2 + p), 1'b0, 1'b0);
      end
      step();
      expect_out("spd1_adv", 4'(3 + p), 1'b1, 1'b0);
    end

    // Switch to speed 11 mid-period: full 16-cycle period from the switch edge.
    step(); step();
    speed = 2'b11;
    step();
    expect_out("spd3_switch", 4'h4, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      check("spd3_wait.tick", {3'b0, tick}, 4'h0);
    end
    step();
    expect_out("spd3_adv", 4'h5, 1'b1, 1'b0);

    // Load on the same edge the divider reaches zero.
    speed = 2'b01;
    step();
    expect_out("spd1_reswitch", 4'h5, 1'b0, 1'b0);
    step(); step(); step();
    check("div_zero.tick", {3'b0, tick}, 4'h0);
    load = 1'b1; load_value = 4'hA;
    step();
    load = 1'b0;
    expect_out("load_prio", 4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("load_wait", 4'hA, 1'b0, 1'b0);
    end
    step();
    expect_out("load_adv", 4'hB, 1'b1, 1'b0);

    // Count down across zero.
    up = 1'b0; speed = 2'b00; load = 1'b1; load_value = 4'h1;
    step();
    load = 1'b0;
    expect_out("down_load", 4'h1, 1'b0, 1'b0);
    step(); expect_out("down0", 4'h0, 1'b1, 1'b0);
    step(); expect_out("downF", 4'hF, 1'b1, 1'b1);
    step(); expect_out("downE", 4'hE, 1'b1, 1'b0);

    // Enable gating at speed 10: 5 disabled cycles delay the advance by 5.
    up = 1'b1; speed = 2'b10;
    step();
    expect_out("spd2_switch", 4'hE, 1'b0, 1'b0);
    step(); step(); step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("gated", 4'hE, 1'b0, 1'b0);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("gate_wait", 4'hE, 1'b0, 1'b0);
    end
    step();
    expect_out("gate_adv", 4'hF, 1'b1, 1'b0);

    // Asynchronous reset mid-period while count is 7.
    load = 1'b1; load_value = 4'h7;
    step();
    load = 1'b0;
    step();
    expect_out("pre_reset", 4'h7, 1'b0, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    expect_out("async_reset", 4'h0, 1'b0, 1'b0);
    speed = 2'b00;
    step();
    expect_out("in_reset", 4'h0, 1'b0, 1'b0);
    resetn = 1'b1;
    step();
    expect_out("post_reset_adv", 4'h1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
